// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller that drives an external dual_port_ram.
// Port A is the write port and port B is the asynchronous read port; only pointers and flags live here.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    // Extra MSB is the wrap bit that distinguishes full from empty.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count = wr_ptr - rd_ptr;

    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    // Gating with rst_n stops the RAM write the moment reset asserts, not at the next edge.
    assign ram_we_a   = push_ok && rst_n;
    assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_din_a  = wr_data;

    assign ram_we_b   = 1'b0;
    assign ram_din_b  = '0;
    assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];

    assign rd_data = empty ? '0 : ram_dout_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flag and pointer sees the pre-edge full/empty state.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

endmodule
